alu_mdu: RTL and testbench
==========================

# alu_mdu

Iterative multiply/divide unit that extends the CPU's single-cycle ALU with `MUL`, `MULU`, `DIV` and `DIVU`. It is parametrised in data width and runs as a sequential shift-add / restoring-division engine with a start/done handshake. It sits beside the combinational ALU in the execute stage. The controller stalls the pipeline while `busy` is high. It writes `resultLo`/`resultHi` and merges `psrOut` into the PSR when `done` pulses.

## Interface
- `DATAWIDTH`, default 16: operand width W. Legal range 4..32.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; sampled only when `busy`=0.
- `opCode`  in  2: `MDUOp_MUL`=0, `MDUOp_MULU`=1, `MDUOp_DIV`=2, `MDUOp_DIVU`=3.
- `rDst`  in  W: multiplicand / dividend.
- `rSrc`  in  W: multiplier / divisor.
- `busy`  out  1: operation in progress; `start` is ignored while high.
- `done`  out  1: one-cycle pulse; results and flags are valid in this cycle.
- `resultLo`  out  W: product low half, or quotient.
- `resultHi`  out  W: product high half, or remainder.
- `psrOut`  out  `PRSWIDTH`: flags Z, N, F at the `defines.v` bit positions; all other bits are 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset values: state=IDLE; `busy`, `done`, `resultLo`, `resultHi` and `psrOut` are all 0.
- IDLE with `start`=1: latch the opcode and operands, then go to CALC with counter=W.
  - Signed ops convert each operand to its magnitude at load and record the result signs.
- CALC, multiply: if the multiplier LSB is 1, add the multiplicand into the high accumulator. Then shift {carry, acc} right by 1.
- CALC, divide: restoring division. Shift {rem, quo} left by 1, trial-subtract the divisor from rem, and keep the difference if it is non-negative while setting the quotient LSB.
- CALC decrements the counter each cycle and goes to FIX when the counter reaches 1.
- FIX:
  - Signed multiply: negate the 2W product if sign(rDst)≠sign(rSrc).
  - Signed divide: negate the quotient if the operand signs differ. Negate the remainder if rDst<0, so division truncates toward zero.
  - Compute flags, register the outputs, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE. Outputs hold until the next accepted `start` completes.
- Flags:
  - Z: set when the full result is zero. That is the 2W product for multiply and the quotient for divide.
  - N: the MSB of `resultHi` for multiply, the MSB of `resultLo` for divide.
  - F, MUL: set when `resultHi` is not the sign-extension of `resultLo`.
  - F, MULU: set when `resultHi`≠0.
  - F, divide: divide-by-zero, or `DIV` of −2^(W−1) by −1.
- Divide by zero (`rSrc`=0), detected at load: skip CALC and FIX and go directly to DONE.
  - `resultLo` is all ones, `resultHi`=`rDst`, F=1, Z=0, N=1.
- `DIV` overflow (−2^(W−1) / −1): `resultLo`=0x8000…0, `resultHi`=0, F=1. The normal path yields this value, so no special case is needed beyond the flag.
- `start` while `busy`=1: ignored. The in-flight operation is unaffected.
- `reset` mid-operation: IDLE on the next edge; all outputs return to their reset values and no `done` is issued.

## Timing
- `start` accepted at edge N: `busy`=1 from N+1 through the DONE cycle inclusive.
- Normal operation: `done` is high in the cycle after edge N+W+1. The latency is W+2 cycles, which is 18 for W=16.
- Divide by zero: `done` is high in the cycle after edge N+1, a latency of 2 cycles.
- A new `start` can be accepted on the edge that ends the DONE cycle, because `busy` drops at that edge. `start` is sampled only while `busy`=0, so there is no back-to-back overlap.
- Counter width: $clog2(W+1).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Add to `defines.v`:
  - `MDUOPWIDTH`=2 and the four `MDUOp_*` codes.
  - The flag bit indices `PSR_Z`, `PSR_N`, `PSR_F`, reusing the existing `PRSWIDTH`.
- The unit is a single module with no sub-module.
- The shared negate helper (two's complement) is a local function used in both load and FIX.

## Test plan
- `MULU` 0xFFFF×0xFFFF (W=16) → `resultHi`=0xFFFE, `resultLo`=0x0001, F=1, Z=0. `done` exactly 18 cycles after `start`.
- `MUL` −3×7 → {Hi,Lo}=0xFFFF_FFEB, N=1, F=0. `MUL` 0×0x1234 → Z=1.
- `DIV` −7/2 → `resultLo`=0xFFFD, `resultHi`=0xFFFF. `DIVU` 0xFFF9/2 → `resultLo`=0x7FFC, `resultHi`=1.
- `DIVU` 100/0 → `resultLo`=0xFFFF, `resultHi`=100, F=1, `done` 2 cycles after `start`. `DIV` 0x8000/0xFFFF → `resultLo`=0x8000, `resultHi`=0, F=1.
- Pulse `start` with new operands 5 cycles into an operation → first result unchanged, second request dropped. Assert `reset` in cycle 10 of CALC → `busy`=0 next cycle, no `done`, outputs 0.
- Randomised sweep at W=8 (exhaustive) and W=16: compare against the `$signed`/unsigned `*`, `/` and `%` operators for each opcode.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Shared opcode, flag-position and state definitions for the iterative multiply/divide unit.
package alu_mdu_pkg;

  localparam int MDUOPWIDTH = 2;

  typedef enum logic [MDUOPWIDTH-1:0] {
    MDUOp_MUL  = 2'd0,
    MDUOp_MULU = 2'd1,
    MDUOp_DIV  = 2'd2,
    MDUOp_DIVU = 2'd3
  } mdu_op_e;

  localparam int PRSWIDTH = 4;
  localparam int PSR_Z    = 0;
  localparam int PSR_N    = 1;
  localparam int PSR_F    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } mdu_state_e;

  function automatic logic [PRSWIDTH-1:0] pack_psr(input logic z, input logic n, input logic f);
    logic [PRSWIDTH-1:0] p;
    p        = '0;
    p[PSR_Z] = z;
    p[PSR_N] = n;
    p[PSR_F] = f;
    return p;
  endfunction

endpackage

// File: rtl/alu_mdu.sv
// Sequential shift-add multiplier / restoring divider with start/done handshake.
// Signed operations run on magnitudes and apply the result signs in a final fix-up cycle.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int DATAWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MDUOPWIDTH-1:0] opCode,
  input  logic [DATAWIDTH-1:0]  rDst,
  input  logic [DATAWIDTH-1:0]  rSrc,
  output logic                  busy,
  output logic                  done,
  output logic [DATAWIDTH-1:0]  resultLo,
  output logic [DATAWIDTH-1:0]  resultHi,
  output logic [PRSWIDTH-1:0]   psrOut
);

  localparam int W  = DATAWIDTH;
  localparam int CW = $clog2(W + 1);

  function automatic logic [2*W-1:0] twos(input logic [2*W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  mdu_state_e    state;
  mdu_op_e       op;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  opnd;
  logic [CW-1:0] cnt;
  logic          neg_q;
  logic          neg_r;
  logic          dz;
  logic          ovf;

  // Load-side operand conditioning
  logic signed [W-1:0] dst_s;
  logic signed [W-1:0] src_s;
  logic                ld_signed;
  logic                dst_neg;
  logic                src_neg;
  logic [W-1:0]        dst_mag;
  logic [W-1:0]        src_mag;
  logic                ld_dz;
  logic                ld_ovf;

  assign dst_s     = rDst;
  assign src_s     = rSrc;
  assign ld_signed = ~opCode[0];
  assign dst_neg   = ld_signed && (dst_s < 0);
  assign src_neg   = ld_signed && (src_s < 0);
  assign dst_mag   = W'(twos({{W{1'b0}}, rDst}, dst_neg));
  assign src_mag   = W'(twos({{W{1'b0}}, rSrc}, src_neg));
  assign ld_dz     = opCode[1] && (rSrc == '0);
  assign ld_ovf    = (opCode == MDUOp_DIV) && (rDst == {1'b1, {(W-1){1'b0}}}) && (rSrc == '1);

  // Iteration datapath
  logic [W:0]   mul_sum;
  logic [W:0]   div_shl;
  logic         div_fit;
  logic [W-1:0] div_diff;

  assign mul_sum  = lo[0] ? ({1'b0, hi} + {1'b0, opnd}) : {1'b0, hi};
  assign div_shl  = {hi, lo[W-1]};
  assign div_fit  = div_shl >= {1'b0, opnd};
  assign div_diff = div_shl[W-1:0] - opnd;

  // Sign fix-up and flag generation
  logic [2*W-1:0] prod;
  logic [W-1:0]   fix_lo;
  logic [W-1:0]   fix_hi;
  logic           fix_z;
  logic           fix_n;
  logic           fix_f;

  always_comb begin
    prod   = twos({hi, lo}, neg_q);
    fix_lo = prod[W-1:0];
    fix_hi = prod[2*W-1:W];
    fix_z  = (prod == '0);
    fix_n  = prod[2*W-1];
    fix_f  = (op == MDUOp_MUL) ? (fix_hi != {W{fix_lo[W-1]}}) : (fix_hi != '0);
    if (op[1]) begin
      fix_lo = W'(twos({{W{1'b0}}, lo}, neg_q));
      fix_hi = W'(twos({{W{1'b0}}, hi}, neg_r));
      fix_z  = (fix_lo == '0);
      fix_n  = fix_lo[W-1];
      fix_f  = ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      resultLo <= '0;
      resultHi <= '0;
      psrOut   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op    <= mdu_op_e'(opCode);
            hi    <= '0;
            lo    <= ld_dz ? rDst : dst_mag;
            opnd  <= src_mag;
            cnt   <= CW'(W);
            neg_q <= dst_neg ^ src_neg;
            neg_r <= dst_neg;
            dz    <= ld_dz;
            ovf   <= ld_ovf;
            busy  <= 1'b1;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (dz) begin
            // lo still holds the raw dividend, which is reported as the remainder
            resultLo <= '1;
            resultHi <= lo;
            psrOut   <= pack_psr(1'b0, 1'b1, 1'b1);
            done     <= 1'b1;
            state    <= ST_DONE;
          end else begin
            if (op[1]) begin
              hi <= div_fit ? div_diff : div_shl[W-1:0];
              lo <= {lo[W-2:0], div_fit};
            end else begin
              hi <= mul_sum[W:1];
              lo <= {mul_sum[0], lo[W-1:1]};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          resultLo <= fix_lo;
          resultHi <= fix_hi;
          psrOut   <= pack_psr(fix_z, fix_n, fix_f);
          done     <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu at W=16 against an arithmetic reference model.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam int W    = 16;
  localparam int MINV = -(1 << (W - 1));
  localparam int MAXV = (1 << (W - 1)) - 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [MDUOPWIDTH-1:0] opCode;
  logic [W-1:0]          rDst;
  logic [W-1:0]          rSrc;
  logic                  busy;
  logic                  done;
  logic [W-1:0]          resultLo;
  logic [W-1:0]          resultHi;
  logic [PRSWIDTH-1:0]   psrOut;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mdu #(.DATAWIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .opCode   (opCode),
    .rDst     (rDst),
    .rSrc     (rSrc),
    .busy     (busy),
    .done     (done),
    .resultLo (resultLo),
    .resultHi (resultHi),
    .psrOut   (psrOut)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic [PRSWIDTH-1:0] psr);
    int     sa, sb, ua, ub, sp, q, r;
    longint up;
    logic   z, n, f;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    z  = 1'b0;
    n  = 1'b0;
    f  = 1'b0;
    lo = '0;
    hi = '0;
    case (op)
      2'd0: begin
        sp = sa * sb;
        {hi, lo} = sp;
        z = (sp == 0);
        n = hi[W-1];
        f = (sp < MINV) || (sp > MAXV);
      end
      2'd1: begin
        up = longint'(ua) * longint'(ub);
        {hi, lo} = up[2*W-1:0];
        z = (up == 0);
        n = hi[W-1];
        f = (up >= (64'd1 << W));
      end
      default: begin
        if (b == '0) begin
          lo = '1;
          hi = a;
          z  = 1'b0;
          n  = 1'b1;
          f  = 1'b1;
        end else begin
          if (op == 2'd2) begin
            q = sa / sb;
            r = sa % sb;
            f = (sa == MINV) && (sb == -1);
          end else begin
            q = ua / ub;
            r = ua % ub;
            f = 1'b0;
          end
          lo = q[W-1:0];
          hi = r[W-1:0];
          z  = (lo == '0);
          n  = lo[W-1];
        end
      end
    endcase
    psr = '0;
    psr[PSR_Z] = z;
    psr[PSR_N] = n;
    psr[PSR_F] = f;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit intrude);
    logic [W-1:0]        elo, ehi;
    logic [PRSWIDTH-1:0] epsr;
    int                  lat, exp_lat;
    model(op, a, b, elo, ehi, epsr);
    exp_lat = (op[1] && b == '0) ? 2 : W + 2;
    @(negedge clk);
    start  = 1'b1;
    opCode = op;
    rDst   = a;
    rSrc   = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("busy_after_start", busy, 1'b1);
    while (!done && lat < 40) begin
      if (intrude && lat == 5) begin
        start  = 1'b1;
        opCode = ~op;
        rDst   = ~a;
        rSrc   = ~b;
      end
      if (intrude && lat == 6) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("busy_in_done", busy, 1'b1);
    check("resultLo", resultLo, elo);
    check("resultHi", resultHi, ehi);
    check("psrOut", psrOut, epsr);
    @(negedge clk);
    check("busy_after_done", busy, 1'b0);
    check("done_single_pulse", done, 1'b0);
  endtask

  task automatic expect_quiet(input string tag);
    int pulses;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check(tag, pulses, 0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      4:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opCode = '0;
    rDst   = '0;
    rSrc   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lo", resultLo, '0);
    check("rst_hi", resultHi, '0);
    check("rst_psr", psrOut, '0);
    reset = 1'b0;

    run_op(2'd1, 16'hFFFF, 16'hFFFF, 1'b0);
    check("mulu_max_lit", {resultHi, resultLo, psrOut[PSR_F], psrOut[PSR_Z]}, {16'hFFFE, 16'h0001, 1'b1, 1'b0});
    run_op(2'd0, 16'hFFFD, 16'd7, 1'b0);
    check("mul_neg_lit", {resultHi, resultLo, psrOut[PSR_N], psrOut[PSR_F]}, {32'hFFFF_FFEB, 1'b1, 1'b0});
    run_op(2'd0, 16'h0000, 16'h1234, 1'b0);
    check("mul_zero_lit", psrOut[PSR_Z], 1'b1);
    run_op(2'd2, 16'hFFF9, 16'd2, 1'b0);
    check("div_neg_lit", {resultLo, resultHi}, {16'hFFFD, 16'hFFFF});
    run_op(2'd3, 16'hFFF9, 16'd2, 1'b0);
    check("divu_lit", {resultLo, resultHi}, {16'h7FFC, 16'h0001});
    run_op(2'd3, 16'd100, 16'd0, 1'b0);
    check("divz_lit", {resultLo, resultHi, psrOut[PSR_F]}, {16'hFFFF, 16'd100, 1'b1});
    run_op(2'd2, 16'h8000, 16'hFFFF, 1'b0);
    check("div_ovf_lit", {resultLo, resultHi, psrOut[PSR_F]}, {16'h8000, 16'h0000, 1'b1});
    run_op(2'd2, 16'h8000, 16'h0000, 1'b0);

    run_op(2'd1, 16'hFFFF, 16'hFFFF, 1'b1);
    expect_quiet("dropped_start");

    @(negedge clk);
    start  = 1'b1;
    opCode = 2'd0;
    rDst   = 16'h1234;
    rSrc   = 16'h0567;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_out", {resultHi, resultLo, psrOut}, '0);
    expect_quiet("midrst_no_done");

    for (int i = 0; i < 320; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      run_op(op, a, b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
